logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Shares one bitwise two-operand logic unit (AND, OR, NAND, NOR, XOR, XNOR) among four requesters. A round-robin arbiter grants one request per cycle and computes the result in that same cycle. The result returns on a registered response port with valid/ready backpressure. The block sits between independent requesters, such as test sequencers and control FSMs, and the shared gate datapath.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  4  per-requester request valid
- req_ready  out  4  per-requester grant; one-hot or zero, combinational
- req_op  in  12  3-bit opcode per requester; requester i uses [3i+2:3i]
- req_a  in  4*WIDTH  operand A per requester; requester i uses slice i
- req_b  in  4*WIDTH  operand B per requester; requester i uses slice i
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  2  index of the requester that owns the response
- rsp_op  out  3  opcode echoed from the granted request
- rsp_data  out  WIDTH  result
- rsp_err  out  1  opcode was illegal
- ops_done  out  16  count of accepted responses, saturating

## Operation
- Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR. Each is a bitwise operation over WIDTH bits.
- Opcodes 6 and 7 are illegal: rsp_data = 0 and rsp_err = 1. They are still granted and still counted.
- accept = !rsp_valid || rsp_ready. When accept = 0, req_ready = 0 (no grant).
- Arbitration: round-robin pointer `last` (2 bits) holds the index of the last granted requester.
  - Priority order is last+1, last+2, last+3, last, all mod 4.
  - The grant goes to the first requester in that order with req_valid set.
- Transfer: requester i's request is taken on a clock edge where req_valid[i] && req_ready[i].
  - On that edge, `last` ← i.
  - The response registers load the result, i, and the opcode; rsp_err is set if the opcode is illegal.
  - rsp_valid ← 1.
- Requester rules:
  - A requester must hold req_valid, op and operands stable until granted.
  - req_ready never depends on the requester's own data, only on the req_valid vector and on state.
- Response handshake:
  - Response data changes only on an edge where rsp_valid && rsp_ready, or on an edge where rsp_valid = 0.
  - On rsp_valid && rsp_ready with no new grant, rsp_valid ← 0.
  - On rsp_valid && rsp_ready with a new grant, rsp_valid stays 1 and the registers load the new response. This gives back-to-back throughput of 1 response/cycle.
- ops_done increments on every edge with rsp_valid && rsp_ready. It saturates at 0xFFFF.
- Implicit states:
  - EMPTY (rsp_valid = 0): grants are allowed.
  - FULL_DRAIN (rsp_valid = 1, rsp_ready = 1): grants are allowed.
  - STALL (rsp_valid = 1, rsp_ready = 0): no grant; response held.
- No requests pending: req_ready = 0 and `last` is unchanged.

## Timing
- Reset values, applied on the first rising edge with rst = 1:
  - rsp_valid = 0, rsp_id = 0, rsp_op = 0, rsp_data = 0, rsp_err = 0, ops_done = 0.
  - last = 3, so requester 0 has first priority.
- req_ready = 0 whenever rst = 1.
- Reset mid-operation discards any pending response and does not count it.
- Latency: the result is on rsp_* in the cycle after the grant edge (1 cycle).
- Throughput: 1 op/cycle under continuous rsp_ready = 1.
- Fairness: with all four requesters continuously valid, each is granted exactly once in every 4 consecutive grants.
- A request arriving at the same edge the arbiter would otherwise go idle is granted combinationally in that cycle. There is no extra bubble.

## Test plan
- Requester 0 only, op 0, a = 0xF0, b = 0x3C, rsp_ready = 1 -> req_ready = 4'b0001 in the same cycle. Next cycle: rsp_valid = 1, rsp_id = 0, rsp_data = 0x30, rsp_err = 0. ops_done = 1 after the accept edge.
- Opcode sweep on requester 2, a = 0x0C, b = 0x0A -> rsp_data 0x08, 0x0E, 0xF7, 0xF1, 0x06, 0xF9 for ops 0–5. Op 6 -> 0x00 with rsp_err = 1.
- All four req_valid held high after reset, rsp_ready = 1 -> grant order 0, 1, 2, 3, 0, 1 with no idle cycles; rsp_valid stays high.
- Response on rsp_*, rsp_ready = 0 for 3 cycles while requester 1 is valid -> req_ready stays 0 and rsp_* are stable. When rsp_ready = 1, requester 1 is granted on that edge and its response follows with no gap.
- rst asserted while rsp_valid = 1 and requests are pending -> next cycle rsp_valid = 0 and ops_done = 0. The first grant after reset goes to requester 0.
- ops_done forced near saturation (65535 accepts) -> holds at 0xFFFF on further accepts.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin shared bitwise logic unit with registered valid/ready response
module logic_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         i_req_valid,
    output logic [3:0]         o_req_ready,
    input  logic [11:0]        i_req_op,
    input  logic [4*WIDTH-1:0] i_req_a,
    input  logic [4*WIDTH-1:0] i_req_b,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [1:0]         o_rsp_id,
    output logic [2:0]         o_rsp_op,
    output logic [WIDTH-1:0]   o_rsp_data,
    output logic               o_rsp_err,
    output logic [15:0]        o_ops_done
);
    logic [1:0]       r_last;
    logic [1:0]       w_gnt_id;
    logic             w_gnt;
    logic             w_accept;
    logic             w_fire;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_res;
    always_comb begin
        w_gnt_id = '0;
        w_gnt    = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (i_req_valid[2'(r_last + 2'(k))]) begin
                w_gnt_id = 2'(r_last + 2'(k));
                w_gnt    = 1'b1;
            end
        end
    end
    assign w_accept    = !o_rsp_valid || i_rsp_ready;
    assign o_req_ready = (w_gnt && w_accept && !rst) ? 4'(1) << w_gnt_id : 4'b0;
    assign w_fire      = |o_req_ready;
    assign w_op        = i_req_op[3*w_gnt_id +: 3];
    assign w_a         = i_req_a[w_gnt_id*WIDTH +: WIDTH];
    assign w_b         = i_req_b[w_gnt_id*WIDTH +: WIDTH];
    assign w_res = (w_op == 3'd0) ?   w_a & w_b  :
                   (w_op == 3'd1) ?   w_a | w_b  :
                   (w_op == 3'd2) ? ~(w_a & w_b) :
                   (w_op == 3'd3) ? ~(w_a | w_b) :
                   (w_op == 3'd4) ?   w_a ^ w_b  :
                   (w_op == 3'd5) ? ~(w_a ^ w_b) : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 2'd3;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_op    <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
            o_ops_done  <= '0;
        end else begin
            if (o_rsp_valid && i_rsp_ready && o_ops_done != 16'hFFFF)
                o_ops_done <= o_ops_done + 16'd1;
            if (w_fire) begin
                r_last      <= w_gnt_id;
                o_rsp_valid <= 1'b1;
                o_rsp_id    <= w_gnt_id;
                o_rsp_op    <= w_op;
                o_rsp_data  <= w_res;
                o_rsp_err   <= w_op[2] & w_op[1];
            end else if (i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed scenario tests for logic_unit_arbiter
module tb_logic_unit_arbiter;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [11:0]  req_op;
    logic [4*W-1:0] req_a;
    logic [4*W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [2:0]   rsp_op;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    logic [15:0]  ops_done;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id), .o_rsp_op(rsp_op), .o_rsp_data(rsp_data),
        .o_rsp_err(rsp_err), .o_ops_done(ops_done)
    );

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[3*i +: 3] = op;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_op, rsp_data, rsp_err} !== '0) begin
            miscompares++; $display("FAIL reset_rsp got v=%b id=%0d op=%0d d=%h e=%b exp all 0", rsp_valid, rsp_id, rsp_op, rsp_data, rsp_err);
        end
        vectors++;
        if (ops_done !== 16'd0) begin miscompares++; $display("FAIL reset_ops got=%0d exp=0", ops_done); end
        req_valid = 4'b0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(0, 3'd0, 8'hF0, 8'h3C);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h30 || rsp_err !== 1'b0 || ops_done !== 16'd0) begin
            miscompares++; $display("FAIL single_rsp got v=%b id=%0d d=%h e=%b ops=%0d exp v=1 id=0 d=30 e=0 ops=0", rsp_valid, rsp_id, rsp_data, rsp_err, ops_done);
        end
        @(negedge clk);
        vectors++;
        if (ops_done !== 16'd1 || rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_accept got ops=%0d v=%b exp ops=1 v=0", ops_done, rsp_valid);
        end
    endtask

    task automatic test_opcode_sweep();
        logic [W-1:0] exp_d [8] = '{8'h08, 8'h0E, 8'hF7, 8'hF1, 8'h06, 8'hF9, 8'h00, 8'h00};
        for (int op = 0; op < 8; op++) begin
            @(negedge clk);
            set_req(2, 3'(op), 8'h0C, 8'h0A);
            req_valid = 4'b0100;
            rsp_ready = 1'b1;
            #1;
            vectors++;
            if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL sweep_ready op=%0d got=%b exp=0100", op, req_ready); end
            @(negedge clk);
            req_valid = 4'b0;
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_op !== 3'(op) || rsp_data !== exp_d[op] || rsp_err !== (op >= 6)) begin
                miscompares++; $display("FAIL sweep_rsp op=%0d got v=%b id=%0d op=%0d d=%h e=%b exp v=1 id=2 d=%h e=%b",
                                        op, rsp_valid, rsp_id, rsp_op, rsp_data, rsp_err, exp_d[op], op >= 6);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d [4] = '{8'h30, 8'hFC, 8'hCF, 8'h03};
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'hF0, 8'h3C);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            vectors++;
            if (req_ready !== 4'(1) << (k % 4)) begin miscompares++; $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1) << (k % 4)); end
            if (k > 0) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4) || rsp_data !== exp_d[(k - 1) % 4]) begin
                    miscompares++; $display("FAIL b2b_rsp k=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                                            k, rsp_valid, rsp_id, rsp_data, (k - 1) % 4, exp_d[(k - 1) % 4]);
                end
            end
            @(negedge clk);
        end
        req_valid = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        do_reset();
        set_req(0, 3'd0, 8'hF0, 8'h3C);
        set_req(1, 3'd4, 8'h0C, 8'h0A);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h30) begin
                miscompares++; $display("FAIL stall_hold k=%0d got rdy=%b v=%b id=%0d d=%h exp rdy=0000 v=1 id=0 d=30", k, req_ready, rsp_valid, rsp_id, rsp_data);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL stall_release got=%b exp=0010", req_ready); end
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h06 || ops_done !== 16'd1) begin
            miscompares++; $display("FAIL stall_next got v=%b id=%0d d=%h ops=%0d exp v=1 id=1 d=06 ops=1", rsp_valid, rsp_id, rsp_data, ops_done);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1110;
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0) begin miscompares++; $display("FAIL midrst_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || ops_done !== 16'd0) begin
            miscompares++; $display("FAIL midrst_state got v=%b ops=%0d exp v=0 ops=0", rsp_valid, ops_done);
        end
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL midrst_first got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        do_reset();
        set_req(0, 3'd1, 8'h01, 8'h02);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        for (int n = 0; n < 65535; n++) @(negedge clk);
        vectors++;
        if (ops_done !== 16'hFFFE) begin miscompares++; $display("FAIL sat_pre got=%h exp=fffe", ops_done); end
        @(negedge clk);
        vectors++;
        if (ops_done !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hit got=%h exp=ffff", ops_done); end
        for (int n = 0; n < 5; n++) @(negedge clk);
        vectors++;
        if (ops_done !== 16'hFFFF || rsp_valid !== 1'b1) begin
            miscompares++; $display("FAIL sat_hold got ops=%h v=%b exp ops=ffff v=1", ops_done, rsp_valid);
        end
        req_valid = 4'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_opcode_sweep();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
